// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: FSM encodings, iteration
// limits and the divide-by-zero quotient.
package md_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [5:0]  CNT_LAST     = 6'd31;
   localparam logic [31:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;

   // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned.
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/md_div_core.sv
// Restoring-divide iteration datapath: one quotient bit per step over
// unsigned 32-bit magnitudes. Exposes the next-step values so the caller can
// sign-fix the final iteration's result as it enters DONE.
module md_div_core
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        step,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] rem_next,
   output logic [31:0] quo_next
);

   logic [31:0] rem_q;
   logic [31:0] quo_q;
   logic [31:0] dvsr_q;
   logic [32:0] trial;

   // Partial remainder stays below 2*divisor, so bit 32 of the trial
   // difference is a clean borrow flag.
   always_comb begin
      trial = {rem_q, quo_q[31]} - {1'b0, dvsr_q};
      if (!trial[32]) begin
         rem_next = trial[31:0];
         quo_next = {quo_q[30:0], 1'b1};
      end else begin
         rem_next = {rem_q[30:0], quo_q[31]};
         quo_next = {quo_q[30:0], 1'b0};
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dvsr_q <= '0;
      end else if (load) begin
         rem_q  <= '0;
         quo_q  <= dividend;
         dvsr_q <= divisor;
      end else if (step) begin
         rem_q  <= rem_next;
         quo_q  <= quo_next;
      end
   end

endmodule

// File: rtl/md_unit.sv
// Iterative multiply/divide unit for the EX stage: radix-2 shift-add multiply
// and restoring divide, 32 cycles each, with a stall request while pending.
module md_unit
   import md_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        op_mult,
   input  logic        op_multu,
   input  logic        op_div,
   input  logic        op_divu,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        advance,
   input  logic        flush,
   output logic        stallreq_for_md,
   output logic        result_valid,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   state_t      state;
   logic [5:0]  cnt;
   logic [31:0] a_mag;
   logic [63:0] prod;
   logic        neg_res;
   logic        neg_rem;
   logic        div_zero;

   logic        any_op;
   logic        is_signed;
   logic [31:0] a_mag_in;
   logic [31:0] b_mag_in;
   logic [32:0] mul_sum;
   logic [63:0] prod_next;
   logic [31:0] rem_next;
   logic [31:0] quo_next;

   assign any_op    = op_mult | op_multu | op_div | op_divu;
   assign is_signed = op_mult | op_div;
   assign a_mag_in  = mag32(src_a, is_signed);
   assign b_mag_in  = mag32(src_b, is_signed);

   assign stallreq_for_md = ((state == S_IDLE) && any_op) || (state == S_MUL) || (state == S_DIV);

   // Shift-add: conditionally add the multiplicand into the upper half, then
   // shift the whole product right, consuming one multiplier bit.
   assign mul_sum   = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, a_mag} : 33'd0);
   assign prod_next = {mul_sum, prod[31:1]};

   md_div_core u_div_core (
      .clk      (clk),
      .rst      (rst),
      .load     ((state == S_IDLE) && any_op && !flush),
      .step     (state == S_DIV),
      .dividend (a_mag_in),
      .divisor  (b_mag_in),
      .rem_next (rem_next),
      .quo_next (quo_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         cnt          <= '0;
         a_mag        <= '0;
         prod         <= '0;
         neg_res      <= 1'b0;
         neg_rem      <= 1'b0;
         div_zero     <= 1'b0;
         result_valid <= 1'b0;
         hi_o         <= '0;
         lo_o         <= '0;
      end else if (flush) begin
         state        <= S_IDLE;
         cnt          <= '0;
         result_valid <= 1'b0;
         hi_o         <= '0;
         lo_o         <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (any_op) begin
                  cnt      <= '0;
                  a_mag    <= a_mag_in;
                  prod     <= {32'd0, b_mag_in};
                  neg_res  <= is_signed & (src_a[31] ^ src_b[31]);
                  neg_rem  <= op_div & src_a[31];
                  div_zero <= (op_div | op_divu) && (src_b == 32'd0);
                  state    <= (op_mult | op_multu) ? S_MUL : S_DIV;
               end
            end
            S_MUL: begin
               prod <= prod_next;
               cnt  <= cnt + 6'd1;
               if (cnt == CNT_LAST) begin
                  state        <= S_DONE;
                  result_valid <= 1'b1;
                  {hi_o, lo_o} <= neg_res ? (~prod_next + 64'd1) : prod_next;
               end
            end
            S_DIV: begin
               cnt <= cnt + 6'd1;
               if (cnt == CNT_LAST) begin
                  state        <= S_DONE;
                  result_valid <= 1'b1;
                  hi_o         <= neg_rem ? (~rem_next + 32'd1) : rem_next;
                  // The remainder already equals src_a for a zero divisor;
                  // only the quotient needs the fixed pattern.
                  lo_o         <= div_zero ? DIV_ZERO_QUO
                                           : (neg_res ? (~quo_next + 32'd1) : quo_next);
               end
            end
            S_DONE: begin
               if (advance) begin
                  state        <= S_IDLE;
                  result_valid <= 1'b0;
                  hi_o         <= '0;
                  lo_o         <= '0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: hand-computed multiply/divide results, latency,
// stall window, DONE hold, flush and mid-operation reset.
module tb_md_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        op_mult, op_multu, op_div, op_divu;
   logic [31:0] src_a, src_b;
   logic        advance, flush;
   logic        stallreq_for_md, result_valid;
   logic [31:0] hi_o, lo_o;

   int n_pass  = 0;
   int n_total = 0;

   md_unit dut (
      .clk             (clk),
      .rst             (rst),
      .op_mult         (op_mult),
      .op_multu        (op_multu),
      .op_div          (op_div),
      .op_divu         (op_divu),
      .src_a           (src_a),
      .src_b           (src_b),
      .advance         (advance),
      .flush           (flush),
      .stallreq_for_md (stallreq_for_md),
      .result_valid    (result_valid),
      .hi_o            (hi_o),
      .lo_o            (lo_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input logic [3:0] ops);
      {op_mult, op_multu, op_div, op_divu} = ops;
   endtask

   // Applies one request at cycle 0 (held while stalled) and checks the stall
   // window 0..32 plus the result at cycle 33; leaves the unit in DONE.
   task automatic run_op(input string tag, input logic [3:0] ops,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int bad;
      bad = 0;
      set_ops(ops);
      src_a = a;
      src_b = b;
      for (int c = 0; c < 33; c++) begin
         @(negedge clk);
         if (stallreq_for_md !== 1'b1 || result_valid !== 1'b0) bad++;
         step();
      end
      set_ops(4'b0000);
      @(negedge clk);
      check({tag, " stall_window"}, bad, 0);
      check({tag, " valid@33"}, {31'd0, result_valid}, 32'd1);
      check({tag, " stall@33"}, {31'd0, stallreq_for_md}, 32'd0);
      check({tag, " hi"}, hi_o, exp_hi);
      check({tag, " lo"}, lo_o, exp_lo);
   endtask

   task automatic retire(input string tag);
      advance = 1'b1;
      step();
      advance = 1'b0;
      @(negedge clk);
      check({tag, " idle_valid"}, {31'd0, result_valid}, 32'd0);
      check({tag, " idle_lo"}, lo_o, 32'd0);
      step();
   endtask

   initial begin
      int pulses;
      rst = 1'b1;
      set_ops(4'b0000);
      src_a   = '0;
      src_b   = '0;
      advance = 1'b0;
      flush   = 1'b0;
      step();
      step();
      @(negedge clk);
      check("reset valid", {31'd0, result_valid}, 32'd0);
      check("reset stall", {31'd0, stallreq_for_md}, 32'd0);
      check("reset hi", hi_o, 32'd0);
      check("reset lo", lo_o, 32'd0);
      rst = 1'b0;
      step();

      // op order in set_ops: {mult, multu, div, divu}
      run_op("multu max", 4'b0100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      retire("multu max");
      run_op("mult -3*5", 4'b1000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      retire("mult -3*5");
      run_op("div -7/2", 4'b0010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      retire("div -7/2");
      run_op("divu 100/0", 4'b0001, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
      retire("divu 100/0");
      run_op("div min/-1", 4'b0010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
      retire("div min/-1");

      // DONE holds for three cycles while a new request is ignored.
      run_op("divu 1000/7", 4'b0001, 32'd1000, 32'd7, 32'd6, 32'd142);
      set_ops(4'b0100);
      src_a = 32'd3;
      src_b = 32'd3;
      for (int c = 0; c < 3; c++) begin
         step();
         @(negedge clk);
         check("hold hi", hi_o, 32'd6);
         check("hold lo", lo_o, 32'd142);
         check("hold stall", {31'd0, stallreq_for_md}, 32'd0);
      end
      set_ops(4'b0000);
      retire("divu 1000/7");

      // Flush at cycle 10 of a divide.
      set_ops(4'b0001);
      src_a = 32'd1000;
      src_b = 32'd7;
      for (int c = 0; c < 10; c++) step();
      flush = 1'b1;
      set_ops(4'b0000);
      step();
      flush = 1'b0;
      @(negedge clk);
      check("flush stall", {31'd0, stallreq_for_md}, 32'd0);
      check("flush valid", {31'd0, result_valid}, 32'd0);
      check("flush hi", hi_o, 32'd0);
      step();
      run_op("multu 6*7", 4'b0100, 32'd6, 32'd7, 32'd0, 32'd42);
      retire("multu 6*7");

      // Flush beats a simultaneous request: the unit must stay in IDLE.
      flush = 1'b1;
      set_ops(4'b1000);
      step();
      flush = 1'b0;
      set_ops(4'b0000);
      @(negedge clk);
      check("flush_vs_op stall", {31'd0, stallreq_for_md}, 32'd0);
      step();

      // Reset at cycle 20 of a multiply.
      set_ops(4'b1000);
      src_a = 32'd123;
      src_b = 32'd456;
      for (int c = 0; c < 20; c++) step();
      rst = 1'b1;
      set_ops(4'b0000);
      step();
      @(negedge clk);
      check("rst_mid stall", {31'd0, stallreq_for_md}, 32'd0);
      check("rst_mid valid", {31'd0, result_valid}, 32'd0);
      check("rst_mid hi", hi_o, 32'd0);
      check("rst_mid lo", lo_o, 32'd0);
      rst = 1'b0;
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
         step();
         @(negedge clk);
         if (result_valid !== 1'b0) pulses++;
      end
      check("rst_mid no_result", pulses, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
